pic_host_sequencer: RTL

- Bus master that configures and services the 8259-style interrupt controller over its RD/WR/A0/CS/INTA pins.
- After reset it writes ICW1–ICW4 and an initial OCW1 mask, then answers INT with the two-pulse INTA cycle.
- It captures the vector, hands it to the CPU side over a valid/ready handshake, and issues EOI (OCW2) and mask updates (OCW1) on request.
- Sits between the CPU core and the controller; the top level owns the DATABUS tristate.

---
 rtl/pic_host_sequencer.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer
//   Bus master for an 8259-style interrupt controller. After reset it writes
//   ICW1..ICW4 and an initial OCW1 mask. It then answers INT with the
//   two-pulse INTA cycle, captures the vector and hands it to the CPU over a
//   valid/ready handshake. It also issues EOI (OCW2) and mask (OCW1) writes
//   on request.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   INT               interrupt request from the controller
//   CS, WR, RD, INTA  active-low bus strobes (RD is reserved, held high)
//   A0                register select
//   DATA_OUT/DATA_OE  write data and DATABUS drive enable (the top owns the tristate)
//   DATA_IN           sampled DATABUS value, captured as the vector
//   init_done         initialisation sequence complete
//   vec_valid/vec_data/vec_ready   vector handshake to the CPU
//   eoi_req, mask_wr, mask_data    single-cycle command requests
//   cmd_ready         high when eoi_req/mask_wr are accepted this cycle
//
// Optional build macro
//   PIC_INT_SYNC_EN   pass INT through a 2-flop synchronizer (2 cycles more latency)

module pic_host_sequencer #(
  parameter logic [4:0]  VECTOR_BASE  = 5'b00100,
  parameter bit          LEVEL_TRIG   = 1'b0,
  parameter bit          SINGLE       = 1'b1,
  parameter logic [7:0]  ICW3_VAL     = 8'h00,
  parameter bit          AEOI         = 1'b0,
  parameter logic [7:0]  INIT_MASK    = 8'h00,
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INT,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic       A0,
  output logic       INTA,
  output logic [7:0] DATA_OUT,
  output logic       DATA_OE,
  input  logic [7:0] DATA_IN,
  output logic       init_done,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  input  logic       vec_ready,
  input  logic       eoi_req,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  output logic       cmd_ready
);

  typedef enum logic [3:0] {
    RST_WAIT, W_ICW1, W_ICW2, W_ICW3, W_ICW4, W_OCW1,
    IDLE, W_MASK, W_EOI, INTA1, INTA_GAP, INTA2, VEC
  } state_t;

  localparam logic [7:0]  ICW1_VAL   = {3'b000, 1'b1, LEVEL_TRIG, 1'b0, SINGLE, 1'b1};
  localparam logic [7:0]  ICW2_VAL   = {VECTOR_BASE, 3'b000};
  localparam logic [7:0]  ICW4_VAL   = {6'b000000, AEOI, 1'b1};
  localparam logic [7:0]  OCW2_EOI   = 8'h20;
  localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES);
  localparam logic [15:0] HOLD_PH    = 16'(PULSE_CYCLES + 1);
  localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES);

  state_t      state;
  state_t      wr_next;
  logic [15:0] phase;
  logic        int_s;

  `ifdef PIC_INT_SYNC_EN
  logic [1:0] int_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) int_sync <= '0;
    else        int_sync <= {int_sync[0], INT};
  end

  assign int_s = int_sync[1];
  `else
  assign int_s = INT;
  `endif

  // Register data for each fixed write (mask data comes straight from the request).
  function automatic logic [7:0] data_of(input state_t s);
    case (s)
      W_ICW1:  return ICW1_VAL;
      W_ICW2:  return ICW2_VAL;
      W_ICW3:  return ICW3_VAL;
      W_ICW4:  return ICW4_VAL;
      W_OCW1:  return INIT_MASK;
      W_EOI:   return OCW2_EOI;
      default: return '0;
    endcase
  endfunction

  function automatic logic a0_of(input state_t s);
    return (s != W_ICW1) && (s != W_EOI);
  endfunction

  // Successor after a write completes; command writes and OCW1 end in IDLE.
  always_comb begin
    wr_next = IDLE;
    case (state)
      W_ICW1:  wr_next = W_ICW2;
      W_ICW2:  wr_next = SINGLE ? W_ICW4 : W_ICW3;
      W_ICW3:  wr_next = W_ICW4;
      W_ICW4:  wr_next = W_OCW1;
      default: wr_next = IDLE;
    endcase
  end

  assign RD = 1'b1;

  // Outputs are loaded on the edge that enters each phase, so every strobe
  // is a flop output. Write phases: 0 = setup, 1..PULSE = WR low, PULSE+1 = hold.
  // Consecutive init writes run back to back, so CS stays low until the last one ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RST_WAIT;
      phase     <= '0;
      CS        <= 1'b1;
      WR        <= 1'b1;
      INTA      <= 1'b1;
      A0        <= 1'b0;
      DATA_OUT  <= '0;
      DATA_OE   <= 1'b0;
      init_done <= 1'b0;
      vec_valid <= 1'b0;
      vec_data  <= '0;
      cmd_ready <= 1'b0;
    end else begin
      case (state)
        RST_WAIT: begin
          state    <= W_ICW1;
          phase    <= '0;
          CS       <= 1'b0;
          WR       <= 1'b1;
          A0       <= a0_of(W_ICW1);
          DATA_OUT <= data_of(W_ICW1);
          DATA_OE  <= 1'b1;
        end

        W_ICW1, W_ICW2, W_ICW3, W_ICW4, W_OCW1, W_MASK, W_EOI: begin
          if (phase == HOLD_PH) begin
            if (wr_next == IDLE) begin
              state     <= IDLE;
              CS        <= 1'b1;
              DATA_OE   <= 1'b0;
              init_done <= 1'b1;
              cmd_ready <= 1'b1;
            end else begin
              state    <= wr_next;
              phase    <= '0;
              WR       <= 1'b1;
              A0       <= a0_of(wr_next);
              DATA_OUT <= data_of(wr_next);
            end
          end else begin
            phase <= phase + 16'd1;
            WR    <= (phase == PULSE_LAST);
          end
        end

        IDLE: begin
          if (mask_wr) begin
            state     <= W_MASK;
            phase     <= '0;
            CS        <= 1'b0;
            WR        <= 1'b1;
            A0        <= 1'b1;
            DATA_OUT  <= mask_data;
            DATA_OE   <= 1'b1;
            cmd_ready <= 1'b0;
          end else if (eoi_req && !AEOI) begin
            state     <= W_EOI;
            phase     <= '0;
            CS        <= 1'b0;
            WR        <= 1'b1;
            A0        <= a0_of(W_EOI);
            DATA_OUT  <= data_of(W_EOI);
            DATA_OE   <= 1'b1;
            cmd_ready <= 1'b0;
          end else if (int_s) begin
            state     <= INTA1;
            phase     <= 16'd1;
            INTA      <= 1'b0;
            cmd_ready <= 1'b0;
          end
        end

        INTA1: begin
          if (phase == PULSE_LAST) begin
            state <= INTA_GAP;
            phase <= 16'd1;
            INTA  <= 1'b1;
          end else begin
            phase <= phase + 16'd1;
          end
        end

        INTA_GAP: begin
          if (phase == GAP_LAST) begin
            state <= INTA2;
            phase <= 16'd1;
            INTA  <= 1'b0;
          end else begin
            phase <= phase + 16'd1;
          end
        end

        INTA2: begin
          if (phase == PULSE_LAST) begin
            state     <= VEC;
            INTA      <= 1'b1;
            vec_data  <= DATA_IN;
            vec_valid <= 1'b1;
          end else begin
            phase <= phase + 16'd1;
          end
        end

        VEC: begin
          if (vec_ready) begin
            state     <= IDLE;
            vec_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: state <= RST_WAIT;
      endcase
    end
  end

endmodule
